mem_stage: RTL and testbench

//  Memory-access stage directly downstream of the execute stage; includes the MEM/WB pipeline register.

---
 rtl/mem_stage.sv | 125 ++++++++++++
 tb/tb_mem_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage with MEM/WB register and fixed-wait-state data memory FSM.
// Optional out-of-range detection is enabled by defining MEM_BOUNDS_CHECK_EN.
module mem_stage #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 3,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WB_EN_in,
    input  logic        MEM_R_EN_in,
    input  logic        MEM_W_EN_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] Val_Rm_in,
    input  logic [3:0]  Reg_Dest_in,
    output logic        freeze,
    output logic        WB_EN_out,
    output logic        MEM_R_EN_out,
    output logic [31:0] ALU_result_out,
    output logic [31:0] Mem_read_value,
    output logic [3:0]  Reg_Dest_out,
    output logic        Mem_error
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   addr_q;
    logic [31:0]     data_q;
    logic            store_q;
    logic            oob_q;
    logic [31:0]     rdata;
    logic [31:0]     mem [DEPTH];

    logic            mem_req;
    logic [AW-1:0]   word_idx;
    logic            oob_in;
    logic            mem_we;

    assign mem_req  = MEM_R_EN_in | MEM_W_EN_in;
    assign word_idx = AW'((ALU_result_in - BASE_ADDR) >> 2);

`ifdef MEM_BOUNDS_CHECK_EN
    localparam logic [32:0] LIMIT = 33'(BASE_ADDR) + 33'(4 * DEPTH);
    assign oob_in = (ALU_result_in < BASE_ADDR) || ({1'b0, ALU_result_in} >= LIMIT);
`else
    assign oob_in = 1'b0;
`endif

    // Gated by reset so an in-flight access releases the pipeline without waiting for a clock.
    assign freeze = !reset && ((state == IDLE && mem_req) || state == BUSY);

    assign mem_we = !reset && state == BUSY && cnt == '0 && store_q && !oob_q;

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[addr_q] <= data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            store_q        <= 1'b0;
            oob_q          <= 1'b0;
            rdata          <= '0;
            WB_EN_out      <= 1'b0;
            MEM_R_EN_out   <= 1'b0;
            ALU_result_out <= '0;
            Mem_read_value <= '0;
            Reg_Dest_out   <= '0;
            Mem_error      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        addr_q  <= word_idx;
                        data_q  <= Val_Rm_in;
                        store_q <= MEM_W_EN_in;
                        oob_q   <= oob_in;
                        cnt     <= CW'(WAIT_CYCLES - 1);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        if (!store_q)
                            rdata <= oob_q ? '0 : mem[addr_q];
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // MEM/WB register: a frozen cycle inserts a bubble so writeback fires once per instruction.
            if (freeze) begin
                WB_EN_out    <= 1'b0;
                MEM_R_EN_out <= 1'b0;
            end else if (state == DONE) begin
                WB_EN_out      <= WB_EN_in;
                MEM_R_EN_out   <= MEM_R_EN_in;
                ALU_result_out <= ALU_result_in;
                Reg_Dest_out   <= Reg_Dest_in;
                Mem_read_value <= rdata;
                Mem_error      <= oob_q;
            end else begin
                WB_EN_out      <= WB_EN_in;
                MEM_R_EN_out   <= 1'b0;
                ALU_result_out <= ALU_result_in;
                Reg_Dest_out   <= Reg_Dest_in;
                Mem_error      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (DEPTH=64, WAIT_CYCLES=3, BASE_ADDR=1024).
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in;
    logic [31:0] ALU_result_in, Val_Rm_in;
    logic [3:0]  Reg_Dest_in;
    logic        freeze, WB_EN_out, MEM_R_EN_out, Mem_error;
    logic [31:0] ALU_result_out, Mem_read_value;
    logic [3:0]  Reg_Dest_out;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int pulse_base;

    mem_stage #(.DEPTH(64), .WAIT_CYCLES(3), .BASE_ADDR(32'd1024)) dut (
        .clk(clk), .reset(reset),
        .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
        .ALU_result_in(ALU_result_in), .Val_Rm_in(Val_Rm_in), .Reg_Dest_in(Reg_Dest_in),
        .freeze(freeze), .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out),
        .ALU_result_out(ALU_result_out), .Mem_read_value(Mem_read_value),
        .Reg_Dest_out(Reg_Dest_out), .Mem_error(Mem_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (WB_EN_out === 1'b1) pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic wb, input logic re, input logic we,
                          input logic [31:0] addr, input logic [31:0] data, input logic [3:0] dest);
        WB_EN_in = wb; MEM_R_EN_in = re; MEM_W_EN_in = we;
        ALU_result_in = addr; Val_Rm_in = data; Reg_Dest_in = dest;
        #1;
    endtask

    task automatic nop();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Drives one memory op, counts frozen cycles (bounded), then clocks the DONE capture.
    task automatic mem_op(input string tag, input logic wb, input logic re, input logic we,
                          input logic [31:0] addr, input logic [31:0] data, input logic [3:0] dest);
        int n;
        set_in(wb, re, we, addr, data, dest);
        n = 0;
        while (freeze === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        check({tag, " freeze_cycles"}, 32'(n), 32'd4);
        check({tag, " wb_before_done"}, 32'(WB_EN_out), 32'd0);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        nop();
        #12;
        check("rst wb_en", 32'(WB_EN_out), 32'd0);
        check("rst alu", ALU_result_out, 32'd0);
        check("rst rdval", Mem_read_value, 32'd0);
        check("rst dest", 32'(Reg_Dest_out), 32'd0);
        check("rst freeze", 32'(freeze), 32'd0);
        check("rst memerr", 32'(Mem_error), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // ALU op passes through in one cycle
        set_in(1'b1, 1'b0, 1'b0, 32'h2A, 32'h0, 4'd5);
        check("alu freeze", 32'(freeze), 32'd0);
        tick();
        check("alu wb_en", 32'(WB_EN_out), 32'd1);
        check("alu result", ALU_result_out, 32'h2A);
        check("alu dest", 32'(Reg_Dest_out), 32'd5);
        check("alu mem_r", 32'(MEM_R_EN_out), 32'd0);

        // Reset mid-access acts before the next edge
        set_in(1'b0, 1'b0, 1'b1, 32'd1040, 32'h99, 4'd0);
        check("midrst freeze_pre", 32'(freeze), 32'd1);
        tick();
        check("midrst busy_freeze", 32'(freeze), 32'd1);
        check("midrst alu_hold", ALU_result_out, 32'h2A);
        #3 reset = 1'b1;
        #1;
        check("midrst freeze", 32'(freeze), 32'd0);
        check("midrst alu", ALU_result_out, 32'd0);
        check("midrst dest", 32'(Reg_Dest_out), 32'd0);
        check("midrst wb_en", 32'(WB_EN_out), 32'd0);
        nop();
        reset = 1'b0;
        tick();

        // Store then load
        mem_op("st1028", 1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 4'd0);
        check("st1028 wb_en", 32'(WB_EN_out), 32'd0);
        nop();
        tick();
        mem_op("ld1028", 1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd3);
        check("ld1028 wb_en", 32'(WB_EN_out), 32'd1);
        check("ld1028 mem_r", 32'(MEM_R_EN_out), 32'd1);
        check("ld1028 data", Mem_read_value, 32'hDEADBEEF);
        check("ld1028 dest", 32'(Reg_Dest_out), 32'd3);
        nop();
        tick();
        check("ld1028 wb_once", 32'(WB_EN_out), 32'd0);
        check("ld1028 mem_r_once", 32'(MEM_R_EN_out), 32'd0);

        // Reset during a store's second BUSY cycle discards it
        mem_op("st1032a", 1'b0, 1'b0, 1'b1, 32'd1032, 32'h11, 4'd0);
        nop();
        tick();
        set_in(1'b0, 1'b0, 1'b1, 32'd1032, 32'h22, 4'd0);
        tick();
        tick();
        #2 reset = 1'b1;
        #2;
        check("st1032b abort_freeze", 32'(freeze), 32'd0);
        nop();
        reset = 1'b0;
        tick();
        mem_op("ld1032", 1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd4);
        check("ld1032 data", Mem_read_value, 32'h11);
        nop();
        tick();

        // Out-of-range store: wraps by default, suppressed with bounds checking
        mem_op("st1024", 1'b0, 1'b0, 1'b1, 32'd1024, 32'h77, 4'd0);
        nop();
        tick();
        mem_op("st1280", 1'b0, 1'b0, 1'b1, 32'd1280, 32'h55, 4'd0);
`ifdef MEM_BOUNDS_CHECK_EN
        check("st1280 memerr", 32'(Mem_error), 32'd1);
`else
        check("st1280 memerr", 32'(Mem_error), 32'd0);
`endif
        nop();
        tick();
        check("memerr clear", 32'(Mem_error), 32'd0);
        mem_op("ld1024", 1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd7);
        check("ld1024 memerr", 32'(Mem_error), 32'd0);
`ifdef MEM_BOUNDS_CHECK_EN
        check("ld1024 data", Mem_read_value, 32'h77);
`else
        check("ld1024 data", Mem_read_value, 32'h55);
`endif
        nop();
        tick();

        // Back-to-back store then load, single writeback pulse
        pulse_base = pulses;
        mem_op("st1036", 1'b0, 1'b0, 1'b1, 32'd1036, 32'hCAFEF00D, 4'd0);
        mem_op("ld1036", 1'b1, 1'b1, 1'b0, 32'd1036, 32'h0, 4'd6);
        check("ld1036 data", Mem_read_value, 32'hCAFEF00D);
        check("ld1036 dest", 32'(Reg_Dest_out), 32'd6);
        nop();
        tick();
        tick();
        check("b2b wb_pulses", 32'(pulses - pulse_base), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
